// File: rtl/sfp_to_fix.sv
// Three-stage sfp (26-bit) to signed fixed-point converter with saturation.
// Define SFP2FIX_ROUND_EN to round right shifts half-up instead of flooring.
module sfp_to_fix #(
  parameter int DW = 32,
  parameter int FW = 16,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req,
  input  logic [25:0]   i_di,
  input  logic          i_cnt_clr,
  output logic          o_vld,
  output logic [DW-1:0] o_do,
  output logic          o_ovf,
  output logic [CW-1:0] o_ovf_cnt
);

  localparam int WW = DW + 18;
  localparam logic signed [9:0] SOFF = 10'(FW - 143);
  localparam logic [8:0] DWS = 9'(DW);
  localparam logic signed [WW-1:0] MAXW =
    {{(WW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [WW-1:0] MINW =
    {{(WW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] PMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] NMIN = {1'b1, {(DW-1){1'b0}}};

  logic signed [17:0]   r_p1_f;
  logic signed [9:0]    r_p1_s;
  logic                 r_p1_vld;
  logic [DW-1:0]        r_p2_r;
  logic                 r_p2_ovf;
  logic                 r_p2_neg;
  logic                 r_p2_vld;

  logic signed [17:0]   w_f;
  logic signed [9:0]    w_s;
  logic                 w_zero;
  logic                 w_left;
  logic                 w_big;
  logic [5:0]           w_lamt;
  logic signed [WW-1:0] w_wide;
  logic                 w_lovf;
  logic [9:0]           w_rneg;
  logic [4:0]           w_rsh;
  logic signed [17:0]   w_fl;
  logic signed [DW-1:0] w_rext;
  logic signed [DW-1:0] w_rres;

  assign w_f = {i_di[25], i_di[16:0]};
  assign w_s = $signed({2'b00, i_di[24:17]}) + SOFF;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_p1_vld <= 1'b0;
      r_p1_f   <= '0;
      r_p1_s   <= '0;
    end else begin
      r_p1_vld <= i_req;
      if (i_req) begin
        r_p1_f <= w_f;
        r_p1_s <= w_s;
      end
    end
  end

  // left shift: wide enough that any in-range shift is exact
  assign w_zero = (r_p1_f == 18'sd0);
  assign w_left = ~r_p1_s[9];
  assign w_big  = (r_p1_s[8:0] >= DWS);
  assign w_lamt = r_p1_s[5:0];
  assign w_wide = $signed({{DW{r_p1_f[17]}}, r_p1_f}) <<< w_lamt;
  assign w_lovf = w_big ? ~w_zero
                : ((w_wide > MAXW) || (w_wide < MINW));

  // right shift: 17 or more leaves only sign bits
  assign w_rneg = -r_p1_s;
  assign w_rsh  = (w_rneg > 10'd17) ? 5'd17 : w_rneg[4:0];
  assign w_fl   = r_p1_f >>> w_rsh;
  assign w_rext = {{(DW-18){w_fl[17]}}, w_fl};

`ifdef SFP2FIX_ROUND_EN
  logic w_rbit;
  assign w_rbit = |(r_p1_f & (18'd1 << (w_rneg - 10'd1)));
  assign w_rres = w_rext + {{(DW-1){1'b0}}, w_rbit};
`else
  assign w_rres = w_rext;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_p2_vld <= 1'b0;
      r_p2_r   <= '0;
      r_p2_ovf <= 1'b0;
      r_p2_neg <= 1'b0;
    end else begin
      r_p2_vld <= r_p1_vld;
      if (r_p1_vld) begin
        r_p2_r   <= w_zero ? '0
                  : (w_left ? w_wide[DW-1:0] : w_rres);
        r_p2_ovf <= w_left & w_lovf;
        r_p2_neg <= r_p1_f[17];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_vld <= 1'b0;
      o_do  <= '0;
      o_ovf <= 1'b0;
    end else begin
      o_vld <= r_p2_vld;
      if (r_p2_vld) begin
        o_do  <= r_p2_ovf ? (r_p2_neg ? NMIN : PMAX) : r_p2_r;
        o_ovf <= r_p2_ovf;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ovf_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_ovf_cnt <= '0;
    end else if (o_vld && o_ovf && (o_ovf_cnt != {CW{1'b1}})) begin
      o_ovf_cnt <= o_ovf_cnt + 1'b1;
    end
  end

endmodule
